fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-issue instruction fetch stage for a 16-entry
// instruction memory. It drives a registered fetch address (PC_out), captures
// the combinational memory read data one cycle later into IR_out, and hands
// it to decode with a valid/ready handshake.
//
// A small FSM controls fetching:
//   IDLE   - waiting for start after reset; start loads RESET_PC
//   RUN    - fetching; branch_taken redirects and flushes, halt stops
//   HALTED - fetching stopped with PC_out held; start resumes from it
//
// Priority inside RUN is branch_taken > halt > fetch. A branch together with
// halt both redirects the PC and stops, so the next start resumes at the
// branch target.
//
// Optional feature, controlled by the FETCH_WRAP_EN macro:
//   defined   - a fetch from the last address wraps PC_out back to 0 and
//               the sequencer keeps running
//   undefined - a fetch from the last address still delivers that
//               instruction, but PC_out stays on the last address and the
//               sequencer drops into HALTED
module fetch_sequencer #(
  parameter int            AW       = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic [31:0]   IR_in,
  input  logic          IR_ready,
  output logic [AW-1:0] PC_out,
  output logic [31:0]   IR_out,
  output logic          IR_valid,
  output logic [AW-1:0] IR_pc,
  output logic [1:0]    state_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [AW-1:0] PC_LAST = '1;
  localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

  state_t state;

  // The IR register can take a new word when it is empty or being drained
  logic fetch_ok;
  // Decode is taking the current instruction this cycle
  logic consumed;
  // The fetch address sits on the last memory entry
  logic at_last;

  assign fetch_ok  = !IR_valid || IR_ready;
  assign consumed  = IR_valid && IR_ready;
  assign at_last   = (PC_out == PC_LAST);
  assign state_out = state;

  // Fetch FSM: state, fetch address and the instruction register all update here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      PC_out   <= RESET_PC;
      IR_out   <= '0;
      IR_pc    <= '0;
      IR_valid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            // Redirect wins over everything; the word in flight is wrong-path
            PC_out   <= branch_target;
            IR_valid <= 1'b0;
            if (halt) begin
              state <= ST_HALTED;
            end
          end else if (halt) begin
            // Stop fetching; a word accepted by decode this cycle is gone
            if (consumed) begin
              IR_valid <= 1'b0;
            end
            state <= ST_HALTED;
          end else if (fetch_ok) begin
            IR_out   <= IR_in;
            IR_pc    <= PC_out;
            IR_valid <= 1'b1;
            if (at_last) begin
`ifdef FETCH_WRAP_EN
              PC_out <= '0;
`else
              state <= ST_HALTED;
`endif
            end else begin
              PC_out <= PC_out + PC_STEP;
            end
          end
          // Otherwise decode is stalling a live word: hold everything
        end

        ST_HALTED: begin
          // PC_out holds so start can resume where fetching stopped
          if (consumed) begin
            IR_valid <= 1'b0;
          end
          if (start) begin
            state <= ST_RUN;
          end
        end

        default: begin
          // IDLE, and the unused encoding which behaves like IDLE
          if (consumed) begin
            IR_valid <= 1'b0;
          end
          if (start) begin
            state  <= ST_RUN;
            PC_out <= RESET_PC;
          end
        end
      endcase
    end
  end

endmodule
